// File: rtl/term_pkg.sv
// Shared definitions for the serial terminal byte interpreter.
// This file holds the control codes, the state encoding and the byte classifier.
package term_pkg;

  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;
  localparam logic [7:0] CC_DEL = 8'h7F;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NL_FILL,
    S_TAB_FILL,
    S_CLR_HOME,
    S_CLR_FILL,
    S_CLR_END
  } term_state_t;

  typedef enum logic [2:0] {
    BC_IGNORE,
    BC_PRINT,
    BC_NEWLINE,
    BC_TAB,
    BC_CLEAR
  } byte_class_t;

  // DEL and everything above it fall outside the printable range and are ignored.
  function automatic byte_class_t classify_byte(input logic [7:0] b);
    byte_class_t cls;
    if (b >= PRINT_LO && b <= PRINT_HI)
      cls = BC_PRINT;
    else if (b == CC_LF || b == CC_CR)
      cls = BC_NEWLINE;
    else if (b == CC_TAB)
      cls = BC_TAB;
    else if (b == CC_FF)
      cls = BC_CLEAR;
    else
      cls = BC_IGNORE;
    return cls;
  endfunction

endpackage

// File: rtl/term_ctrl.sv
// Byte-stream interpreter: writes printable bytes at the cursor and expands
// CR/LF, TAB and FF into one-cell-per-clock blank fills.
module term_ctrl
  import term_pkg::*;
#(
  parameter logic [7:0] BLANK = 8'h20,
  parameter int         TAB_W = 8,
  parameter int         COL_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_last_row,
  input  logic             i_last_col,
  input  logic [COL_W-1:0] i_col,
  output logic             o_cmd_home,
  output logic             o_cmd_advance,
  output logic             o_we,
  output logic [7:0]       o_wdata,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam logic [COL_W-1:0] TAB_MASK = COL_W'(TAB_W - 1);

  term_state_t state_reg, state_next;
  byte_class_t rx_class;
  logic        tab_stop;
  logic        fill;

  assign rx_class = classify_byte(i_rx_data);
  // The current cell is the last one before a tab stop when its low bits are all ones.
  assign tab_stop = (i_col & TAB_MASK) == TAB_MASK;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    fill          = 1'b0;
    o_cmd_home    = 1'b0;
    o_cmd_advance = 1'b0;
    o_we          = 1'b0;
    o_wdata       = 8'h00;
    o_busy        = (state_reg != S_IDLE);
    o_overrun     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (i_rx_valid) begin
          case (rx_class)
            BC_PRINT: begin
              o_we          = 1'b1;
              o_cmd_advance = 1'b1;
              o_wdata       = i_rx_data;
            end
            BC_NEWLINE: state_next = S_NL_FILL;
            BC_TAB:     state_next = S_TAB_FILL;
            BC_CLEAR:   state_next = S_CLR_HOME;
            default:    state_next = S_IDLE;
          endcase
        end
      end
      S_NL_FILL: begin
        fill = 1'b1;
        if (i_last_col)
          state_next = S_IDLE;
      end
      S_TAB_FILL: begin
        fill = 1'b1;
        if (tab_stop || i_last_col)
          state_next = S_IDLE;
      end
      S_CLR_HOME: begin
        o_cmd_home = 1'b1;
        state_next = S_CLR_FILL;
      end
      S_CLR_FILL: begin
        fill = 1'b1;
        if (i_last_row && i_last_col)
          state_next = S_CLR_END;
      end
      S_CLR_END: begin
        o_cmd_home = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (fill) begin
      o_we          = 1'b1;
      o_cmd_advance = 1'b1;
      o_wdata       = BLANK;
    end

    // No buffering: anything arriving mid-fill is lost and flagged.
    if (o_busy && i_rx_valid)
      o_overrun = 1'b1;

    // Reset silences every output in its own cycle, including a same-cycle byte.
    if (i_rst) begin
      state_next    = S_IDLE;
      o_cmd_home    = 1'b0;
      o_cmd_advance = 1'b0;
      o_we          = 1'b0;
      o_wdata       = 8'h00;
      o_busy        = 1'b0;
      o_overrun     = 1'b0;
    end
  end

endmodule

// File: tb/tb_term_ctrl.sv
// Directed bench for term_ctrl with a 17x60 cursor/RAM model of the position controller.
module tb_term_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic       home, adv, we, busy, ovr;
  logic [7:0] wdata;

  logic       ld_pos = 1'b0;
  logic [4:0] ld_row = '0;
  logic [5:0] ld_col = '0;

  logic [7:0] ram [0:16][0:59];
  int we_cnt = 0, home_cnt = 0, adv_cnt = 0, busy_cnt = 0, ovr_cnt = 0;
  int n_checks = 0, n_fail = 0;

  term_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .i_last_row    (cur_row == 5'd16),
    .i_last_col    (cur_col == 6'd59),
    .i_col         (cur_col),
    .o_cmd_home    (home),
    .o_cmd_advance (adv),
    .o_we          (we),
    .o_wdata       (wdata),
    .o_busy        (busy),
    .o_overrun     (ovr)
  );

  // Position controller model: row is held on the last row when wrapping.
  always @(posedge clk) begin
    if (we) ram[cur_row][cur_col] <= wdata;
    if (ld_pos) begin
      cur_row <= ld_row;
      cur_col <= ld_col;
    end else if (home) begin
      cur_row <= '0;
      cur_col <= '0;
    end else if (adv) begin
      if (cur_col == 6'd59) begin
        cur_col <= '0;
        if (cur_row != 5'd16) cur_row <= cur_row + 5'd1;
      end else begin
        cur_col <= cur_col + 6'd1;
      end
    end
    if (we)   we_cnt   <= we_cnt + 1;
    if (home) home_cnt <= home_cnt + 1;
    if (adv)  adv_cnt  <= adv_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (ovr)  ovr_cnt  <= ovr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cursor(input int r, input int c);
    @(negedge clk);
    ld_row = 5'(r);
    ld_col = 6'(c);
    ld_pos = 1'b1;
    @(posedge clk);
    #1 ld_pos = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    #1;
    $display("rx %02h at (%0d,%0d): we=%0d adv=%0d home=%0d busy=%0d ovr=%0d",
             b, cur_row, cur_col, we, adv, home, busy, ovr);
  endtask

  task automatic release_rx();
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_timeout", 32'(busy), 32'd0);
  endtask

  int we0, busy0, home0, ovr0, nonblank, srow, scol;

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    set_cursor(0, 0);

    // Reset beats a same-cycle printable byte.
    strobe(8'h41);
    check_val("rst_we", 32'(we), 0);
    check_val("rst_adv", 32'(adv), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_ovr", 32'(ovr), 0);
    release_rx();
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_outs", {28'd0, we, adv, home, busy}, 0);

    // Printable characters.
    strobe(8'h41);
    check_val("A_we_adv", {30'd0, we, adv}, 32'h3);
    check_val("A_wdata", 32'(wdata), 32'h41);
    release_rx();
    strobe(8'h42);
    check_val("B_wdata", 32'(wdata), 32'h42);
    check_val("B_busy", 32'(busy), 0);
    release_rx();
    @(negedge clk);
    check_val("ram_A", 32'(ram[0][0]), 32'h41);
    check_val("ram_B", 32'(ram[0][1]), 32'h42);
    check_val("col_after_AB", 32'(cur_col), 2);

    // Newline from column 57.
    set_cursor(2, 57);
    we0 = we_cnt; busy0 = busy_cnt;
    strobe(8'h0D);
    check_val("cr_strobe_we", 32'(we), 0);
    release_rx();
    wait_idle(100);
    check_val("cr_writes", 32'(we_cnt - we0), 3);
    check_val("cr_busy", 32'(busy_cnt - busy0), 3);
    check_val("cr_pos", {cur_row, 3'd0, cur_col}, {5'd3, 3'd0, 6'd0});
    check_val("cr_blank", 32'(ram[2][58]), 32'h20);

    // Tabs from column 3, 8 and near the right edge.
    set_cursor(5, 3);
    we0 = we_cnt;
    strobe(8'h09); release_rx(); wait_idle(100);
    check_val("tab3_writes", 32'(we_cnt - we0), 5);
    check_val("tab3_col", 32'(cur_col), 8);
    we0 = we_cnt;
    strobe(8'h09); release_rx(); wait_idle(100);
    check_val("tab8_writes", 32'(we_cnt - we0), 8);
    check_val("tab8_col", 32'(cur_col), 16);
    set_cursor(6, 58);
    we0 = we_cnt;
    strobe(8'h09); release_rx(); wait_idle(100);
    check_val("tab58_writes", 32'(we_cnt - we0), 2);
    check_val("tab58_pos", {cur_row, 3'd0, cur_col}, {5'd7, 3'd0, 6'd0});

    // Linefeed on the last row keeps the row.
    set_cursor(16, 10);
    we0 = we_cnt;
    strobe(8'h0A); release_rx(); wait_idle(100);
    check_val("lf_last_writes", 32'(we_cnt - we0), 50);
    check_val("lf_last_pos", {cur_row, 3'd0, cur_col}, {5'd16, 3'd0, 6'd0});

    // Clear with an overrun byte in the middle.
    set_cursor(9, 20);
    we0 = we_cnt; busy0 = busy_cnt; home0 = home_cnt; ovr0 = ovr_cnt;
    strobe(8'h0C);
    release_rx();
    check_val("ff_home_first", 32'(home), 1);
    repeat (100) @(negedge clk);
    strobe(8'h58);
    check_val("ovr_pulse", 32'(ovr), 1);
    check_val("ovr_wdata", 32'(wdata), 32'h20);
    release_rx();
    wait_idle(1100);
    check_val("ff_writes", 32'(we_cnt - we0), 1020);
    check_val("ff_busy", 32'(busy_cnt - busy0), 1022);
    check_val("ff_homes", 32'(home_cnt - home0), 2);
    check_val("ff_ovr", 32'(ovr_cnt - ovr0), 1);
    check_val("ff_pos", {cur_row, 3'd0, cur_col}, 0);
    nonblank = 0;
    for (int r = 0; r < 17; r++)
      for (int c = 0; c < 60; c++)
        if (ram[r][c] != 8'h20) nonblank++;
    check_val("ff_screen_blank", 32'(nonblank), 0);

    // Reset at clear cycle 500 aborts without a closing home.
    strobe(8'h0C);
    release_rx();
    repeat (499) @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h51;
    #1;
    check_val("midrst_outs", {27'd0, we, adv, home, busy, ovr}, 0);
    we0 = we_cnt; home0 = home_cnt; ovr0 = ovr_cnt;
    srow = int'(cur_row); scol = int'(cur_col);
    @(posedge clk);
    #1 begin rst = 1'b0; rx_valid = 1'b0; end
    @(negedge clk);
    check_val("midrst_busy_after", 32'(busy), 0);
    repeat (5) @(negedge clk);
    check_val("midrst_no_writes", 32'(we_cnt - we0), 0);
    check_val("midrst_no_home", 32'(home_cnt - home0), 0);
    check_val("midrst_no_ovr", 32'(ovr_cnt - ovr0), 0);
    check_val("midrst_pos", 32'(int'(cur_row) * 64 + int'(cur_col)), 32'(srow * 64 + scol));
    check_val("midrst_mid_screen", 32'(srow), 8);

    // Non-printable codes are ignored.
    strobe(8'h00);
    check_val("nul_outs", {27'd0, we, adv, home, busy, ovr}, 0);
    release_rx();
    strobe(8'h80);
    check_val("x80_outs", {27'd0, we, adv, home, busy, ovr}, 0);
    release_rx();
    strobe(8'h7F);
    check_val("del_outs", {27'd0, we, adv, home, busy, ovr}, 0);
    release_rx();
    @(negedge clk);
    check_val("ignored_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/term_ctrl.md
# term_ctrl

Byte-stream interpreter for the serial terminal. Sits between the UART receiver and the cursor position controller: takes one received byte per strobe, writes printable characters into text RAM at the current cursor cell, and drives the position controller's home/advance commands. It expands control codes (CR/LF, TAB, FF) into multi-cycle fill sequences, one cell per clock.

## Interface
Parameters:
- `BLANK`, 8'h20: fill character for newline, tab and clear.
- `TAB_W`, 8: tab stop spacing in columns; power of two, at most 32.
- `COL_W`, 6: width of the column input.

Ports:
- `i_clk`  in  1: single clock.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_rx_data`  in  8: received byte.
- `i_rx_valid`  in  1: one-cycle strobe; `i_rx_data` is valid in that cycle.
- `i_last_row`  in  1: cursor is on the last row, from the position controller.
- `i_last_col`  in  1: cursor is on the last column, from the position controller.
- `i_col`  in  `COL_W`: current cursor column, from the position controller.
- `o_cmd_home`  out  1: home-cursor command pulse.
- `o_cmd_advance`  out  1: advance-cursor command pulse.
- `o_we`  out  1: text RAM write enable. The address is the position controller's current row/col.
- `o_wdata`  out  8: text RAM write data.
- `o_busy`  out  1: high while a fill sequence runs.
- `o_overrun`  out  1: one-cycle pulse when a byte is dropped.

## Operation
- States: IDLE, NL_FILL, TAB_FILL, CLR_HOME, CLR_FILL, CLR_END.
- IDLE, on `i_rx_valid`, decoded from the byte:
  - 0x20..0x7E: assert `o_we` with `o_wdata` = byte and assert `o_cmd_advance` in the same cycle. Stay in IDLE.
  - 0x0A or 0x0D: enter NL_FILL.
  - 0x09: enter TAB_FILL.
  - 0x0C: enter CLR_HOME.
  - Anything else (other codes below 0x20, and 0x7F..0xFF): ignored, no outputs.
- NL_FILL: every cycle, write `BLANK` and advance. Leave for IDLE after the cycle in which `i_last_col`=1.
  - The cursor ends at column 0 of the next row.
  - On the last row the controller holds the row, so the cursor returns to column 0 of the same row and that row is blanked.
- TAB_FILL: every cycle, write `BLANK` and advance. Leave for IDLE after the cycle in which (`i_col`+1) mod `TAB_W` = 0, or `i_last_col`=1.
  - A TAB always writes at least one cell.
- CLR_HOME: assert `o_cmd_home` for one cycle, then go to CLR_FILL.
- CLR_FILL: every cycle, write `BLANK` and advance. Go to CLR_END after the cycle in which `i_last_row` and `i_last_col` are both 1.
- CLR_END: assert `o_cmd_home` for one cycle, then go to IDLE.
- `o_busy` = 1 in every state except IDLE.
- A byte arriving with `i_rx_valid` while `o_busy`=1 is dropped and pulses `o_overrun` in the same cycle. There is no buffering.
- `o_we` and `o_cmd_advance` are always asserted together. `o_cmd_home` is never asserted together with either of them.

## Timing
- All outputs are combinational decodes of the registered state and the inputs; they are valid in the same cycle.
- RAM write and cursor advance take effect on the same edge; the RAM captures the pre-advance address.
- Printable character: 1 cycle, and the next byte is accepted in the following cycle.
- Newline from column c: 60−c cycles with the default 60-column controller.
- Tab from column c: `TAB_W` − (c mod `TAB_W`) cycles, clipped at the last column.
- Clear of a 17×60 screen: 1 + 1020 + 1 = 1022 cycles busy.
- Reset:
  - State returns to IDLE. All outputs are 0 in the reset cycle and the cycle after.
  - Reset mid-fill aborts immediately. No closing home is issued; the cursor stays wherever it was.
- Reset takes priority over `i_rx_valid` in the same cycle; that byte is discarded with no `o_overrun` pulse.

## Structure
- Shared package `term_pkg`:
  - Control-code constants: `CC_LF`, `CC_CR`, `CC_TAB`, `CC_FF`, `CC_DEL`.
  - State encoding enum.
  - Printable-range bounds.
- Single module; no sub-module is needed.
- The byte classifier is a function in `term_pkg` (`classify_byte`), shared with any future escape-sequence parser.

## Test plan
- Reset, then bytes 'A' (0x41) and 'B' at column 0 → `o_we`+`o_cmd_advance` in each strobe cycle; `o_wdata` = 0x41, then 0x42; `o_busy` stays 0.
- Cursor at column 57, send 0x0D → 3 cycles of `o_we` with `o_wdata`=0x20; `o_busy` high for exactly those 3 cycles; cursor at column 0 of the next row.
- Cursor at column 3, send 0x09 → 5 blank writes; ends at column 8. Cursor at column 8, send 0x09 → 8 writes.
- Send 0x0C → one home pulse, 1020 blank writes, one home pulse; busy for 1022 cycles; final cursor at 0,0.
- During a clear, strobe 'X' → `o_overrun` pulses; 'X' is not written; the clear completes unchanged.
- Assert `i_rst` at clear cycle 500 → no further writes or home; `o_busy`=0 the next cycle. Then 0x00 and 0x80 produce no outputs.
